dmem_access_ctrl: RTL and testbench

Data-memory access controller sitting directly downstream of the load/store byte-lane decoder. It takes the per-lane write/read masks plus address, store data and funct3 for one load or store, runs a request/grant/response handshake with the data memory, and returns an aligned, sign- or zero-extended load result to write-back. It also reports bus errors: an illegal mask or a response timeout.

---
 rtl/dmem_access_ctrl_pkg.sv | 20 ++
 rtl/dmem_access_ctrl_if.sv | 24 ++
 rtl/dmem_access_ctrl_load_extend.sv | 50 +++++
 rtl/dmem_access_ctrl.sv | 125 ++++++++++++
 tb/tb_dmem_access_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared encodings for the data-memory access controller: funct3 codes,
// FSM state type and the default response timeout.
package dmem_access_ctrl_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam int unsigned DEFAULT_TIMEOUT = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Request/grant/response bus between the access controller (master) and
// the data memory (slave).
interface dmem_access_ctrl_if #(
   parameter int unsigned ADDR_W = 32
) ();
   logic              d_req_o;
   logic              d_we_o;
   logic [ADDR_W-1:0] d_addr_o;
   logic [3:0]        d_be_o;
   logic [31:0]       d_wdata_o;
   logic              d_gnt_i;
   logic              d_rvalid_i;
   logic [31:0]       d_rdata_i;

   modport master (
      output d_req_o, d_we_o, d_addr_o, d_be_o, d_wdata_o,
      input  d_gnt_i, d_rvalid_i, d_rdata_i
   );

   modport slave (
      input  d_req_o, d_we_o, d_addr_o, d_be_o, d_wdata_o,
      output d_gnt_i, d_rvalid_i, d_rdata_i
   );
endinterface

// File: rtl/dmem_access_ctrl_load_extend.sv
// Combinational lane logic: load byte/half extraction with sign or zero
// extension, and store data replication across byte lanes.
module load_extend
   import dmem_access_ctrl_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rdata,
   input  logic [31:0] wdata,
   output logic [31:0] rdata_ext,
   output logic [31:0] wdata_rep
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[7:0];
      unique case (addr_lo)
         2'd0: byte_sel = rdata[7:0];
         2'd1: byte_sel = rdata[15:8];
         2'd2: byte_sel = rdata[23:16];
         2'd3: byte_sel = rdata[31:24];
         default: byte_sel = rdata[7:0];
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      rdata_ext = rdata;
      case (funct3)
         F3_LB:   rdata_ext = {{24{byte_sel[7]}}, byte_sel};
         F3_LH:   rdata_ext = {{16{half_sel[15]}}, half_sel};
         F3_LBU:  rdata_ext = {24'h0, byte_sel};
         F3_LHU:  rdata_ext = {16'h0, half_sel};
         default: rdata_ext = rdata;
      endcase
   end

   // Store encodings share the LB/LH/LW codes (SB/SH/SW).
   always_comb begin
      wdata_rep = wdata;
      case (funct3)
         F3_LB:   wdata_rep = {4{wdata[7:0]}};
         F3_LH:   wdata_rep = {2{wdata[15:0]}};
         default: wdata_rep = wdata;
      endcase
   end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: one load or store per start, with lane
// handling, illegal-mask rejection and a response timeout.
module dmem_access_ctrl
   import dmem_access_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
   parameter int unsigned ADDR_W         = 32
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              start_i,
   input  logic              mem_read_i,
   input  logic              mem_write_i,
   input  logic [2:0]        funct3_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   input  logic [3:0]        we_mask_i,
   input  logic [3:0]        rd_mask_i,
   dmem_access_ctrl_if.master d_bus,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [31:0]       rdata_o
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [2:0]         funct3_q;
   logic [1:0]         addr_lo_q;
   logic [3:0]         mask_c;
   logic [2:0]         lane_f3_c;
   logic [31:0]        rdata_ext_c;
   logic [31:0]        wdata_rep_c;
   logic               timeout_c;

   assign mask_c    = mem_write_i ? we_mask_i : rd_mask_i;
   // Store replication is needed at accept time, load extension later.
   assign lane_f3_c = (state_q == ST_IDLE) ? funct3_i : funct3_q;
   assign timeout_c = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));
   assign busy_o    = (state_q != ST_IDLE);

   load_extend u_load_extend (
      .funct3    (lane_f3_c),
      .addr_lo   (addr_lo_q),
      .rdata     (d_bus.d_rdata_i),
      .wdata     (wdata_i),
      .rdata_ext (rdata_ext_c),
      .wdata_rep (wdata_rep_c)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q         <= ST_IDLE;
         cnt_q           <= '0;
         funct3_q        <= '0;
         addr_lo_q       <= '0;
         d_bus.d_req_o   <= 1'b0;
         d_bus.d_we_o    <= 1'b0;
         d_bus.d_addr_o  <= '0;
         d_bus.d_be_o    <= '0;
         d_bus.d_wdata_o <= '0;
         done_o          <= 1'b0;
         err_o           <= 1'b0;
         rdata_o         <= '0;
      end else begin
         done_o <= 1'b0;
         err_o  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_i && (mem_write_i || mem_read_i)) begin
                  funct3_q        <= funct3_i;
                  addr_lo_q       <= addr_i[1:0];
                  d_bus.d_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
                  d_bus.d_be_o    <= mask_c;
                  d_bus.d_we_o    <= mem_write_i;
                  d_bus.d_wdata_o <= wdata_rep_c;
                  if (mask_c == 4'b0000) begin
                     state_q <= ST_DONE;
                     done_o  <= 1'b1;
                     err_o   <= 1'b1;
                  end else begin
                     state_q       <= ST_REQ;
                     d_bus.d_req_o <= 1'b1;
                     cnt_q         <= '0;
                  end
               end
            end
            ST_REQ: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (d_bus.d_gnt_i) begin
                  d_bus.d_req_o <= 1'b0;
                  if (d_bus.d_we_o) begin
                     state_q <= ST_DONE;
                     done_o  <= 1'b1;
                  end else begin
                     state_q <= ST_WAIT;
                  end
               end else if (timeout_c) begin
                  d_bus.d_req_o <= 1'b0;
                  state_q       <= ST_DONE;
                  done_o        <= 1'b1;
                  err_o         <= 1'b1;
               end
            end
            ST_WAIT: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (d_bus.d_rvalid_i) begin
                  rdata_o <= rdata_ext_c;
                  state_q <= ST_DONE;
                  done_o  <= 1'b1;
               end else if (timeout_c) begin
                  state_q <= ST_DONE;
                  done_o  <= 1'b1;
                  err_o   <= 1'b1;
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with hand-computed expectations.
module tb_dmem_access_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        start_i;
   logic        mem_read_i;
   logic        mem_write_i;
   logic [2:0]  funct3_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [3:0]  we_mask_i;
   logic [3:0]  rd_mask_i;
   logic        busy_o;
   logic        done_o;
   logic        err_o;
   logic [31:0] rdata_o;

   int checks   = 0;
   int failures = 0;
   logic [31:0] last_rdata = 32'h0;

   dmem_access_ctrl_if #(.ADDR_W(32)) bus ();

   dmem_access_ctrl #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .start_i     (start_i),
      .mem_read_i  (mem_read_i),
      .mem_write_i (mem_write_i),
      .funct3_i    (funct3_i),
      .addr_i      (addr_i),
      .wdata_i     (wdata_i),
      .we_mask_i   (we_mask_i),
      .rd_mask_i   (rd_mask_i),
      .d_bus       (bus),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .rdata_o     (rdata_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic start_access(input logic wr, input logic rd, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [3:0] wem, input logic [3:0] rdm);
      start_i     = 1'b1;
      mem_write_i = wr;
      mem_read_i  = rd;
      funct3_i    = f3;
      addr_i      = addr;
      wdata_i     = wd;
      we_mask_i   = wem;
      rd_mask_i   = rdm;
   endtask

   task automatic test_reset();
      rst_n_i = 1'b0; start_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
      funct3_i = 3'b0; addr_i = 32'h0; wdata_i = 32'h0; we_mask_i = 4'h0; rd_mask_i = 4'h0;
      bus.d_gnt_i = 1'b0; bus.d_rvalid_i = 1'b0; bus.d_rdata_i = 32'h0;
      tick(); tick();
      rst_n_i = 1'b1;
      checks++; if ({bus.d_req_o, bus.d_we_o, done_o, err_o, busy_o} !== 5'b0) begin
         $display("FAIL reset_ctrl got=%b exp=00000", {bus.d_req_o, bus.d_we_o, done_o, err_o, busy_o}); failures++; end
      checks++; if ({bus.d_addr_o, bus.d_be_o, bus.d_wdata_o, rdata_o} !== 100'h0) begin
         $display("FAIL reset_data got=%h exp=0", {bus.d_addr_o, bus.d_be_o, bus.d_wdata_o, rdata_o}); failures++; end
      tick();
   endtask

   task automatic test_store(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [3:0] m,
                             input logic [31:0] exp_addr, input logic [31:0] exp_wd, input int gnt_dly);
      start_access(1'b1, 1'b0, f3, addr, wd, m, 4'h0);
      tick();
      start_i = 1'b0;
      for (int i = 0; i < gnt_dly; i++) begin
         checks++; if ({bus.d_req_o, done_o} !== 2'b10) begin
            $display("FAIL %s_wait req/done got=%b exp=10", nm, {bus.d_req_o, done_o}); failures++; end
         tick();
      end
      checks++; if ({bus.d_req_o, bus.d_we_o, busy_o, done_o} !== 4'b1110) begin
         $display("FAIL %s_req req/we/busy/done got=%b exp=1110", nm, {bus.d_req_o, bus.d_we_o, busy_o, done_o}); failures++; end
      checks++; if (bus.d_addr_o !== exp_addr) begin
         $display("FAIL %s_addr got=%h exp=%h", nm, bus.d_addr_o, exp_addr); failures++; end
      checks++; if (bus.d_be_o !== m) begin
         $display("FAIL %s_be got=%b exp=%b", nm, bus.d_be_o, m); failures++; end
      checks++; if (bus.d_wdata_o !== exp_wd) begin
         $display("FAIL %s_wdata got=%h exp=%h", nm, bus.d_wdata_o, exp_wd); failures++; end
      bus.d_gnt_i = 1'b1;
      tick();
      bus.d_gnt_i = 1'b0;
      checks++; if ({done_o, err_o, bus.d_req_o} !== 3'b100) begin
         $display("FAIL %s_done done/err/req got=%b exp=100", nm, {done_o, err_o, bus.d_req_o}); failures++; end
      tick();
      checks++; if ({done_o, busy_o} !== 2'b00) begin
         $display("FAIL %s_idle done/busy got=%b exp=00", nm, {done_o, busy_o}); failures++; end
   endtask

   task automatic test_load(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [3:0] m, input logic [31:0] rd, input logic [31:0] exp,
                            input int gnt_dly, input int rv_dly);
      start_access(1'b0, 1'b1, f3, addr, 32'hFFFF_FFFF, 4'h0, m);
      tick();
      start_i = 1'b0;
      for (int i = 0; i < gnt_dly; i++) tick();
      checks++; if ({bus.d_req_o, bus.d_we_o, bus.d_be_o} !== {2'b10, m}) begin
         $display("FAIL %s_req req/we/be got=%b exp=%b", nm, {bus.d_req_o, bus.d_we_o, bus.d_be_o}, {2'b10, m}); failures++; end
      checks++; if (bus.d_addr_o !== {addr[31:2], 2'b00}) begin
         $display("FAIL %s_addr got=%h exp=%h", nm, bus.d_addr_o, {addr[31:2], 2'b00}); failures++; end
      bus.d_gnt_i = 1'b1;
      tick();
      bus.d_gnt_i = 1'b0;
      bus.d_rdata_i = 32'h5A5A_5A5A;
      for (int i = 0; i < rv_dly; i++) tick();
      checks++; if ({bus.d_req_o, done_o, busy_o} !== 3'b001) begin
         $display("FAIL %s_wait req/done/busy got=%b exp=001", nm, {bus.d_req_o, done_o, busy_o}); failures++; end
      bus.d_rvalid_i = 1'b1;
      bus.d_rdata_i  = rd;
      tick();
      bus.d_rvalid_i = 1'b0;
      checks++; if ({done_o, err_o} !== 2'b10) begin
         $display("FAIL %s_done done/err got=%b exp=10", nm, {done_o, err_o}); failures++; end
      checks++; if (rdata_o !== exp) begin
         $display("FAIL %s_rdata got=%h exp=%h", nm, rdata_o, exp); failures++; end
      last_rdata = exp;
      tick();
      checks++; if ({done_o, busy_o} !== 2'b00) begin
         $display("FAIL %s_idle done/busy got=%b exp=00", nm, {done_o, busy_o}); failures++; end
   endtask

   task automatic test_illegal_mask();
      start_access(1'b0, 1'b1, 3'b001, 32'h101, 32'h0, 4'h0, 4'b0000);
      tick();
      start_i = 1'b0;
      checks++; if ({done_o, err_o, bus.d_req_o} !== 3'b110) begin
         $display("FAIL illegal_done done/err/req got=%b exp=110", {done_o, err_o, bus.d_req_o}); failures++; end
      tick();
      checks++; if ({done_o, err_o, bus.d_req_o, busy_o} !== 4'b0000) begin
         $display("FAIL illegal_idle done/err/req/busy got=%b exp=0000", {done_o, err_o, bus.d_req_o, busy_o}); failures++; end
   endtask

   task automatic test_timeout();
      start_access(1'b0, 1'b1, 3'b010, 32'h200, 32'h0, 4'h0, 4'hF);
      tick();
      start_i = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         checks++; if ({bus.d_req_o, done_o} !== 2'b10) begin
            $display("FAIL timeout_req_c%0d req/done got=%b exp=10", c, {bus.d_req_o, done_o}); failures++; end
         tick();
      end
      checks++; if ({done_o, err_o, bus.d_req_o} !== 3'b110) begin
         $display("FAIL timeout_done done/err/req got=%b exp=110", {done_o, err_o, bus.d_req_o}); failures++; end
      checks++; if (rdata_o !== last_rdata) begin
         $display("FAIL timeout_rdata got=%h exp=%h", rdata_o, last_rdata); failures++; end
      tick();
      checks++; if (busy_o !== 1'b0) begin
         $display("FAIL timeout_idle busy got=%b exp=0", busy_o); failures++; end
   endtask

   task automatic test_ignored_inputs();
      start_access(1'b0, 1'b0, 3'b010, 32'h300, 32'h0, 4'hF, 4'hF);
      bus.d_rvalid_i = 1'b1;
      bus.d_rdata_i  = 32'h1357_9BDF;
      tick();
      start_i = 1'b0;
      bus.d_rvalid_i = 1'b0;
      checks++; if ({busy_o, bus.d_req_o, done_o} !== 3'b000) begin
         $display("FAIL ignore_start busy/req/done got=%b exp=000", {busy_o, bus.d_req_o, done_o}); failures++; end
      checks++; if (rdata_o !== last_rdata) begin
         $display("FAIL ignore_rvalid rdata got=%h exp=%h", rdata_o, last_rdata); failures++; end
   endtask

   task automatic test_reset_mid();
      start_access(1'b0, 1'b1, 3'b010, 32'h400, 32'h0, 4'h0, 4'hF);
      tick();
      start_i = 1'b0;
      bus.d_gnt_i = 1'b1;
      tick();
      bus.d_gnt_i = 1'b0;
      rst_n_i = 1'b0;
      tick();
      rst_n_i = 1'b1;
      last_rdata = 32'h0;
      checks++; if ({bus.d_req_o, busy_o, done_o, err_o} !== 4'b0000) begin
         $display("FAIL rstmid_ctrl req/busy/done/err got=%b exp=0000", {bus.d_req_o, busy_o, done_o, err_o}); failures++; end
      checks++; if ({bus.d_addr_o, bus.d_be_o, rdata_o} !== 68'h0) begin
         $display("FAIL rstmid_data got=%h exp=0", {bus.d_addr_o, bus.d_be_o, rdata_o}); failures++; end
      bus.d_rvalid_i = 1'b1;
      bus.d_rdata_i  = 32'hCAFE_F00D;
      tick();
      bus.d_rvalid_i = 1'b0;
      checks++; if ({done_o, busy_o, rdata_o} !== 34'h0) begin
         $display("FAIL rstmid_rvalid done/busy/rdata got=%h exp=0", {done_o, busy_o, rdata_o}); failures++; end
   endtask

   task automatic test_back_to_back();
      start_access(1'b1, 1'b0, 3'b010, 32'h500, 32'h1111_2222, 4'hF, 4'h0);
      tick();
      bus.d_gnt_i = 1'b1;
      tick();
      bus.d_gnt_i = 1'b0;
      checks++; if ({done_o, bus.d_req_o} !== 2'b10) begin
         $display("FAIL b2b_done done/req got=%b exp=10", {done_o, bus.d_req_o}); failures++; end
      addr_i = 32'h600;
      tick();
      checks++; if ({busy_o, bus.d_req_o, done_o} !== 3'b000) begin
         $display("FAIL b2b_idle busy/req/done got=%b exp=000", {busy_o, bus.d_req_o, done_o}); failures++; end
      tick();
      start_i = 1'b0;
      checks++; if ({bus.d_req_o, bus.d_addr_o} !== {1'b1, 32'h600}) begin
         $display("FAIL b2b_second req/addr got=%h exp=%h", {bus.d_req_o, bus.d_addr_o}, {1'b1, 32'h600}); failures++; end
      bus.d_gnt_i = 1'b1;
      tick();
      bus.d_gnt_i = 1'b0;
      checks++; if ({done_o, err_o} !== 2'b10) begin
         $display("FAIL b2b_second_done done/err got=%b exp=10", {done_o, err_o}); failures++; end
      tick();
   endtask

   initial begin
      test_reset();
      test_store("sw",      3'b010, 32'h100, 32'hDEAD_BEEF, 4'b1111, 32'h100, 32'hDEAD_BEEF, 0);
      test_store("sb",      3'b000, 32'h102, 32'h0000_00A5, 4'b0100, 32'h100, 32'hA5A5_A5A5, 1);
      test_store("sh_late", 3'b001, 32'h10E, 32'h1234_BEEF, 4'b1100, 32'h10C, 32'hBEEF_BEEF, 3);
      test_load("lb",  3'b000, 32'h103, 4'b1000, 32'h80FF_1234, 32'hFFFF_FF80, 0, 1);
      test_load("lhu", 3'b101, 32'h102, 4'b1100, 32'h80FF_1234, 32'h0000_80FF, 1, 0);
      test_load("lh",  3'b001, 32'h102, 4'b1100, 32'h80FF_1234, 32'hFFFF_80FF, 0, 0);
      test_load("lbu", 3'b100, 32'h101, 4'b0010, 32'h80FF_9234, 32'h0000_0092, 0, 0);
      test_load("lw",  3'b010, 32'h100, 4'b1111, 32'h80FF_1234, 32'h80FF_1234, 0, 0);
      test_load("lh0", 3'b001, 32'h100, 4'b0011, 32'h0000_7FFE, 32'h0000_7FFE, 0, 0);
      test_illegal_mask();
      test_timeout();
      test_ignored_inputs();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
